// File: rtl/spike_ingress_queue.sv
// Spike ingress queue: circular FIFO from host to grid with a registered one-packet-per-cycle output.
// Optional stall watchdog enabled by defining SPIKE_INGRESS_WATCHDOG_EN.
module spike_ingress_queue #(
    parameter int DEPTH       = 4,
    parameter int STALL_LIMIT = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [7:0]               in_data_a,
    input  logic [7:0]               in_data_b,
    input  logic                     stall,
    output logic [7:0]               spike_in_data_a,
    output logic [7:0]               spike_in_data_b,
    output logic                     spike_in_valid,
    output logic                     fault_inject,
    output logic [$clog2(DEPTH):0]   occupancy
);

    localparam int PW = $clog2(DEPTH);
    localparam int OW = PW + 1;

    logic [15:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push;
    logic          pop;
    logic [OW-1:0] occ_next;

    assign in_ready = (occupancy < OW'(DEPTH));
    assign push     = in_valid && in_ready;
    // Pop only looks at registered occupancy, so an entry written this edge is never read this edge.
    assign pop      = (occupancy != '0) && (!stall || fault_inject);

    always_comb begin
        occ_next = occupancy;
        if (push && !pop) begin
            occ_next = occupancy + 1'b1;
        end else if (pop && !push) begin
            occ_next = occupancy - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_data_a, in_data_b};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            occupancy       <= '0;
            spike_in_valid  <= 1'b0;
            spike_in_data_a <= 8'h00;
            spike_in_data_b <= 8'h00;
        end else begin
            occupancy <= occ_next;
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr          <= rd_ptr + 1'b1;
                spike_in_valid  <= 1'b1;
                spike_in_data_a <= mem[rd_ptr][15:8];
                spike_in_data_b <= mem[rd_ptr][7:0];
            end else begin
                spike_in_valid  <= 1'b0;
                spike_in_data_a <= 8'h00;
                spike_in_data_b <= 8'h00;
            end
        end
    end

`ifdef SPIKE_INGRESS_WATCHDOG_EN
    logic [7:0] stall_cnt;
    logic [7:0] stall_cnt_next;

    // Counts consecutive stalled edges while data is waiting; saturates at 255.
    always_comb begin
        stall_cnt_next = 8'd0;
        if (stall && (occupancy != '0)) begin
            stall_cnt_next = (stall_cnt == 8'hFF) ? stall_cnt : stall_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt    <= 8'd0;
            fault_inject <= 1'b0;
        end else begin
            stall_cnt <= stall_cnt_next;
            if (occ_next == '0) begin
                fault_inject <= 1'b0;
            end else if (stall_cnt_next == 8'(STALL_LIMIT)) begin
                fault_inject <= 1'b1;
            end
        end
    end
`else
    assign fault_inject = 1'b0;
`endif

endmodule

// File: tb/tb_spike_ingress_queue.sv
// Scoreboard bench for spike_ingress_queue: queue-based reference model, negedge monitor,
// directed scenarios plus randomized traffic.
module tb_spike_ingress_queue;

    localparam int DEPTH       = 4;
    localparam int STALL_LIMIT = 16;
    localparam int OW          = $clog2(DEPTH) + 1;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b1;
    logic          in_valid  = 1'b0;
    logic [7:0]    in_data_a = 8'h00;
    logic [7:0]    in_data_b = 8'h00;
    logic          stall     = 1'b0;
    logic          in_ready;
    logic [7:0]    spike_in_data_a;
    logic [7:0]    spike_in_data_b;
    logic          spike_in_valid;
    logic          fault_inject;
    logic [OW-1:0] occupancy;

    int compared   = 0;
    int mismatched = 0;

    logic [15:0] model_q[$];
    logic [15:0] exp_q[$];
    bit          model_valid = 1'b0;
    bit          model_fault = 1'b0;
    int          model_cnt   = 0;
    int          m_occ;
    bit          m_pop;
    logic [15:0] m_item;
    logic [15:0] mon_exp;

    spike_ingress_queue #(.DEPTH(DEPTH), .STALL_LIMIT(STALL_LIMIT)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_data_a       (in_data_a),
        .in_data_b       (in_data_b),
        .stall           (stall),
        .spike_in_data_a (spike_in_data_a),
        .spike_in_data_b (spike_in_data_b),
        .spike_in_valid  (spike_in_valid),
        .fault_inject    (fault_inject),
        .occupancy       (occupancy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit v, input logic [7:0] a, input logic [7:0] b, input bit s);
        in_valid  = v;
        in_data_a = a;
        in_data_b = b;
        stall     = s;
        @(posedge clk);
        #1;
    endtask

    // Reference model: a plain queue of packets; each edge decides pop/push from the rules.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_q.delete();
                exp_q.delete();
                model_valid = 1'b0;
                model_fault = 1'b0;
                model_cnt   = 0;
            end else begin
                m_occ = model_q.size();
                m_pop = (m_occ > 0) && (!stall || model_fault);
                model_valid = m_pop;
                if (m_pop) begin
                    m_item = model_q.pop_front();
                    exp_q.push_back(m_item);
                end
                if (in_valid && (m_occ < DEPTH)) begin
                    model_q.push_back({in_data_a, in_data_b});
                end
`ifdef SPIKE_INGRESS_WATCHDOG_EN
                if (stall && (m_occ > 0)) begin
                    model_cnt = (model_cnt < 255) ? model_cnt + 1 : 255;
                end else begin
                    model_cnt = 0;
                end
                if (model_q.size() == 0) begin
                    model_fault = 1'b0;
                end else if (model_cnt == STALL_LIMIT) begin
                    model_fault = 1'b1;
                end
`endif
            end
        end
    end

    // Monitor: compares DUT outputs against the model/scoreboard away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                checkOutput("mon_valid", 32'(spike_in_valid), 32'(model_valid));
                if (spike_in_valid) begin
                    if (exp_q.size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("[TB] FAIL mon_spurious: got packet 0x%02h%02h, expected none at %0t",
                                 spike_in_data_a, spike_in_data_b, $time);
                    end else begin
                        mon_exp = exp_q.pop_front();
                        checkOutput("mon_data", 32'({spike_in_data_a, spike_in_data_b}), 32'(mon_exp));
                    end
                end else begin
                    if (model_valid && exp_q.size() > 0) begin
                        mon_exp = exp_q.pop_front();
                    end
                    checkOutput("mon_idle_data", 32'({spike_in_data_a, spike_in_data_b}), 32'h0);
                end
                checkOutput("mon_occupancy", 32'(occupancy), 32'(model_q.size()));
                checkOutput("mon_in_ready", 32'(in_ready), 32'(model_q.size() < DEPTH));
                checkOutput("mon_fault", 32'(fault_inject), 32'(model_fault));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int emitted;
        bit s;

        #1 rst_n = 1'b0;
        #2;
        checkOutput("rst_valid", 32'(spike_in_valid), 32'h0);
        checkOutput("rst_occupancy", 32'(occupancy), 32'h0);
        checkOutput("rst_in_ready", 32'(in_ready), 32'h1);
        checkOutput("rst_fault", 32'(fault_inject), 32'h0);
        checkOutput("rst_data", 32'({spike_in_data_a, spike_in_data_b}), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single packet, one-edge latency
        applyStimulus(1'b1, 8'h12, 8'h34, 1'b0);
        checkOutput("t1_occ_after_push", 32'(occupancy), 32'h1);
        checkOutput("t1_valid_early", 32'(spike_in_valid), 32'h0);
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
        checkOutput("t1_valid", 32'(spike_in_valid), 32'h1);
        checkOutput("t1_data_a", 32'(spike_in_data_a), 32'h12);
        checkOutput("t1_data_b", 32'(spike_in_data_b), 32'h34);
        checkOutput("t1_occ_end", 32'(occupancy), 32'h0);

        // Fill under stall, reject overflow, then drain in order
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 8'(8'hA0 + i), 8'(8'hB0 + i), 1'b1);
        end
        checkOutput("t2_occ_full", 32'(occupancy), 32'h4);
        checkOutput("t2_in_ready_full", 32'(in_ready), 32'h0);
        applyStimulus(1'b1, 8'hEE, 8'hEE, 1'b1);
        checkOutput("t2_occ_overflow", 32'(occupancy), 32'h4);
        checkOutput("t2_valid_stalled", 32'(spike_in_valid), 32'h0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
            checkOutput("t2_valid", 32'(spike_in_valid), 32'h1);
            checkOutput("t2_data_a", 32'(spike_in_data_a), 32'(8'hA0 + i));
            checkOutput("t2_data_b", 32'(spike_in_data_b), 32'(8'hB0 + i));
        end
        checkOutput("t2_occ_empty", 32'(occupancy), 32'h0);
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
        checkOutput("t2_no_extra", 32'(spike_in_valid), 32'h0);

        // Streaming 20 packets across pointer wrap
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b1, 8'(i), 8'(8'hFF - i), 1'b0);
            checkOutput("t3_occ", 32'(occupancy), 32'h1);
            if (i > 0) begin
                checkOutput("t3_valid", 32'(spike_in_valid), 32'h1);
                checkOutput("t3_data_a", 32'(spike_in_data_a), 32'(i - 1));
            end
        end
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
        checkOutput("t3_last_a", 32'(spike_in_data_a), 32'h13);
        checkOutput("t3_occ_end", 32'(occupancy), 32'h0);

`ifdef SPIKE_INGRESS_WATCHDOG_EN
        // Watchdog escalation: second push edge is the first counted stalled edge
        applyStimulus(1'b1, 8'hC1, 8'hD1, 1'b1);
        applyStimulus(1'b1, 8'hC2, 8'hD2, 1'b1);
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1'b0, 8'h00, 8'h00, 1'b1);
            checkOutput("t4_fault", 32'(fault_inject), 32'(i == 14));
            checkOutput("t4_occ_hold", 32'(occupancy), 32'h2);
        end
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b1);
        checkOutput("t4_valid1", 32'(spike_in_valid), 32'h1);
        checkOutput("t4_data1", 32'(spike_in_data_a), 32'hC1);
        checkOutput("t4_fault_mid", 32'(fault_inject), 32'h1);
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b1);
        checkOutput("t4_valid2", 32'(spike_in_valid), 32'h1);
        checkOutput("t4_data2", 32'(spike_in_data_a), 32'hC2);
        checkOutput("t4_occ_end", 32'(occupancy), 32'h0);
        checkOutput("t4_fault_clear", 32'(fault_inject), 32'h0);
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
`else
        // Without the watchdog a stall holds the queue indefinitely
        applyStimulus(1'b1, 8'hC1, 8'hD1, 1'b1);
        applyStimulus(1'b1, 8'hC2, 8'hD2, 1'b1);
        emitted = 0;
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'b0, 8'h00, 8'h00, 1'b1);
            if (spike_in_valid || fault_inject) begin
                emitted++;
            end
        end
        checkOutput("t4_no_activity", 32'(emitted), 32'h0);
        checkOutput("t4_occ_hold", 32'(occupancy), 32'h2);
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
        checkOutput("t4_data1", 32'(spike_in_data_a), 32'hC1);
        applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
        checkOutput("t4_data2", 32'(spike_in_data_a), 32'hC2);
        checkOutput("t4_occ_end", 32'(occupancy), 32'h0);
`endif

        // Asynchronous reset with entries queued
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 8'(8'h51 + i), 8'(8'h61 + i), 1'b1);
        end
        checkOutput("t5_occ_before", 32'(occupancy), 32'h3);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t5_occ", 32'(occupancy), 32'h0);
        checkOutput("t5_in_ready", 32'(in_ready), 32'h1);
        checkOutput("t5_valid", 32'(spike_in_valid), 32'h0);
        checkOutput("t5_fault", 32'(fault_inject), 32'h0);
        checkOutput("t5_data", 32'({spike_in_data_a, spike_in_data_b}), 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        emitted = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
            if (spike_in_valid) begin
                emitted++;
            end
        end
        checkOutput("t5_no_emit", 32'(emitted), 32'h0);

        // Randomized traffic with varying stall density, including a long solid stall
        for (int i = 0; i < 400; i++) begin
            case (i / 50)
                1, 5:    s = ($urandom_range(0, 99) < 80);
                3:       s = 1'b1;
                default: s = ($urandom_range(0, 99) < 20);
            endcase
            applyStimulus($urandom_range(0, 99) < 60, 8'($urandom), 8'($urandom), s);
        end
        for (int i = 0; i < 2 * DEPTH + 4; i++) begin
            applyStimulus(1'b0, 8'h00, 8'h00, 1'b0);
        end
        checkOutput("rand_drain_occ", 32'(occupancy), 32'h0);
        checkOutput("rand_scoreboard_left", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
